// File: rtl/cpu86_mem_model_pkg.sv
// rtl/cpu86_mem_model_pkg.sv - shared types and byte-image access for the cpu86 memory model
package cpu86_mem_model_pkg;

   localparam int MAX_DATA_W = 128;

   // One pipeline stage: a sampled read word and its valid flag.
   typedef struct packed {
      logic                  valid;
      logic [MAX_DATA_W-1:0] data;
   } pipe_stage_t;

   function automatic int lane_count(input int data_w);
      return data_w / 8;
   endfunction

   // Byte image shared by every instance; bytes never written read back as zero.
   logic [7:0] mem_image [int unsigned];

   function automatic void c_mem_write_b(input int unsigned addr, input logic [7:0] data);
      mem_image[addr] = data;
   endfunction

   function automatic logic [7:0] c_mem_read_b(input int unsigned addr);
      if (mem_image.exists(addr) != 0) return mem_image[addr];
      return 8'h00;
   endfunction

endpackage

// File: rtl/cpu86_mem_model_fifo.sv
// rtl/cpu86_mem_model_fifo.sv - synchronous FIFO with same-cycle push/pop
module cpu86_mem_model_fifo
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] store [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign do_push = push && (!full || pop);
   assign do_pop  = pop && !empty;
   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign rdata   = store[rd_ptr];

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Storage array; contents are don't-care while empty, so no reset.
   always_ff @(posedge clk) begin
      if (do_push) store[wr_ptr] <= wdata;
   end

   // Pointers and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= next_ptr(wr_ptr);
         if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/cpu86_mem_model_stream.sv
// rtl/cpu86_mem_model_stream.sv - streaming cpu86 memory model with fixed-latency in-order reads
module cpu86_mem_model_stream
   import cpu86_mem_model_pkg::*;
#(
   parameter int ADDR_W     = 25,
   parameter int DATA_W     = 32,
   parameter int LATENCY    = 1,
   parameter int RESP_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cmd_s_tvalid,
   output logic                cmd_s_tready,
   input  logic                cmd_s_we,
   input  logic [ADDR_W-1:0]   cmd_s_addr,
   input  logic [DATA_W/8-1:0] cmd_s_wmask,
   input  logic [DATA_W-1:0]   cmd_s_wdata,
   output logic                rd_m_tvalid,
   input  logic                rd_m_tready,
   output logic [DATA_W-1:0]   rd_m_tdata,
   output logic [31:0]         wr_cnt,
   output logic [31:0]         rd_cnt
);
   localparam int NB    = lane_count(DATA_W);
   localparam int OUT_W = $clog2(RESP_DEPTH + 1);

   if (LATENCY < 1 || LATENCY > 16) begin : g_bad_latency
      $error("LATENCY must be in 1..16");
   end
   if ((DATA_W % 8) != 0 || DATA_W < 8 || DATA_W > MAX_DATA_W) begin : g_bad_data_w
      $error("DATA_W must be a multiple of 8 in 8..128");
   end
   if (RESP_DEPTH < 1) begin : g_bad_depth
      $error("RESP_DEPTH must be at least 1");
   end
   if (ADDR_W + $clog2(NB) > 31) begin : g_bad_addr_w
      $error("byte address does not fit in 31 bits");
   end

   logic              rst_q;
   logic [OUT_W-1:0]  outstanding;
   pipe_stage_t       pipe [LATENCY];
   logic              fifo_full;
   logic              fifo_empty;
   logic [DATA_W-1:0] fifo_head;
   logic              accept;
   logic              rd_accept;
   logic              wr_accept;
   logic              rd_hs;
   logic [31:0]       base_addr;
   logic              unused_bits;

   // Writes share the read credit gate so commands retire strictly in order.
   assign cmd_s_tready = !rst_q && (outstanding < OUT_W'(RESP_DEPTH));
   assign accept       = cmd_s_tvalid && cmd_s_tready;
   assign rd_accept    = accept && !cmd_s_we;
   assign wr_accept    = accept && cmd_s_we;
   assign rd_hs        = rd_m_tvalid && rd_m_tready;
   assign base_addr    = 32'(cmd_s_addr) * 32'(NB);
   assign rd_m_tvalid  = !fifo_empty;
   assign rd_m_tdata   = fifo_empty ? '0 : fifo_head;
   assign unused_bits  = ^{fifo_full, pipe[LATENCY-1].data};

   // Lane 0 is the most-significant byte and sits at the lowest byte address.
   function automatic logic [DATA_W-1:0] read_word(input logic [31:0] base);
      logic [DATA_W-1:0] w;
      w = '0;
      for (int i = 0; i < NB; i++) w[DATA_W-1-8*i -: 8] = c_mem_read_b(base + 32'(i));
      return w;
   endfunction

   // Memory access at the accept edge and the non-stalling read pipeline.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < LATENCY; k++) pipe[k] <= '0;
      end else begin
         if (wr_accept) begin
            for (int i = 0; i < NB; i++) begin
               if (!cmd_s_wmask[i]) c_mem_write_b(base_addr + 32'(i), cmd_s_wdata[DATA_W-1-8*i -: 8]);
            end
         end
         pipe[0].valid <= rd_accept;
         if (rd_accept) pipe[0].data <= MAX_DATA_W'(read_word(base_addr));
         for (int k = 1; k < LATENCY; k++) pipe[k] <= pipe[k-1];
      end
   end

   // Reset shadow, read credit counter and event counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rst_q       <= 1'b1;
         outstanding <= '0;
         wr_cnt      <= '0;
         rd_cnt      <= '0;
      end else begin
         rst_q <= 1'b0;
         case ({rd_accept, rd_hs})
            2'b10:   outstanding <= outstanding + 1'b1;
            2'b01:   outstanding <= outstanding - 1'b1;
            default: outstanding <= outstanding;
         endcase
         if (wr_accept) wr_cnt <= wr_cnt + 32'd1;
         if (rd_hs)     rd_cnt <= rd_cnt + 32'd1;
      end
   end

   cpu86_mem_model_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (RESP_DEPTH)
   ) u_resp_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (pipe[LATENCY-1].valid),
      .wdata (pipe[LATENCY-1].data[DATA_W-1:0]),
      .pop   (rd_hs),
      .rdata (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   a_cmd_hold: assert property (@(posedge clk) disable iff (rst)
      (cmd_s_tvalid && !cmd_s_tready) |=> (cmd_s_tvalid && $stable(cmd_s_we) && $stable(cmd_s_addr)
                                           && $stable(cmd_s_wmask) && $stable(cmd_s_wdata)));

   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      pipe[LATENCY-1].valid |-> (!fifo_full || rd_hs));

endmodule

// File: tb/tb_cpu86_mem_model_stream.sv
// tb/tb_cpu86_mem_model_stream.sv - scoreboard bench for cpu86_mem_model_stream
module tb_cpu86_mem_model_stream;
   localparam int ADDR_W     = 25;
   localparam int DATA_W     = 64;
   localparam int LATENCY    = 5;
   localparam int RESP_DEPTH = 4;
   localparam int NB         = DATA_W / 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              cmd_s_tvalid = 1'b0;
   logic              cmd_s_tready;
   logic              cmd_s_we = 1'b0;
   logic [ADDR_W-1:0] cmd_s_addr = '0;
   logic [NB-1:0]     cmd_s_wmask = '0;
   logic [DATA_W-1:0] cmd_s_wdata = '0;
   logic              rd_m_tvalid;
   logic              rd_m_tready = 1'b0;
   logic [DATA_W-1:0] rd_m_tdata;
   logic [31:0]       wr_cnt;
   logic [31:0]       rd_cnt;

   always #5 clk = ~clk;

   cpu86_mem_model_stream #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LATENCY(LATENCY), .RESP_DEPTH(RESP_DEPTH)
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_s_tvalid(cmd_s_tvalid), .cmd_s_tready(cmd_s_tready), .cmd_s_we(cmd_s_we),
      .cmd_s_addr(cmd_s_addr), .cmd_s_wmask(cmd_s_wmask), .cmd_s_wdata(cmd_s_wdata),
      .rd_m_tvalid(rd_m_tvalid), .rd_m_tready(rd_m_tready), .rd_m_tdata(rd_m_tdata),
      .wr_cnt(wr_cnt), .rd_cnt(rd_cnt)
   );

   typedef struct {
      logic [DATA_W-1:0] data;
      int                acc_cyc;
   } exp_t;

   exp_t       exp_q[$];
   bit [7:0]   mdl [int unsigned];
   int         n_vec = 0;
   int         n_err = 0;
   int         cyc = 0;
   int         n_pop = 0;
   int         n_rd_acc = 0;
   int         mdl_wr = 0;
   int         ready_mode = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Response ready policy: 0 = held low, 1 = held high, 2 = random.
   always @(posedge clk) begin
      #2;
      case (ready_mode)
         0:       rd_m_tready = 1'b0;
         1:       rd_m_tready = 1'b1;
         default: rd_m_tready = 1'($urandom_range(0, 1));
      endcase
   end

   // Monitor: every handshake is checked against the head of the expectation queue.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && rd_m_tvalid && rd_m_tready) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_resp got=%h required=none", rd_m_tdata);
         end else begin
            e = exp_q.pop_front();
            if (rd_m_tdata !== e.data) begin
               n_err++;
               $display("FAIL resp_data got=%h required=%h", rd_m_tdata, e.data);
            end
            n_vec++;
            if (cyc < e.acc_cyc + LATENCY) begin
               n_err++;
               $display("FAIL resp_early got_cycle=%0d required_min=%0d", cyc, e.acc_cyc + LATENCY);
            end
         end
         n_pop++;
      end
   end

   function automatic logic [DATA_W-1:0] model_read(input int unsigned a);
      logic [DATA_W-1:0] w;
      w = '0;
      for (int i = 0; i < NB; i++) begin
         w = w << 8;
         if (mdl.exists(a * NB + i) != 0) w[7:0] = mdl[a * NB + i];
      end
      return w;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s got=%h required=%h", name, act, req);
      end
   endtask

   // Issue one command starting in the low clock phase; returns at the negedge after acceptance.
   task automatic send(input logic we, input logic [ADDR_W-1:0] a, input logic [NB-1:0] m,
                       input logic [DATA_W-1:0] d);
      bit rdy;
      cmd_s_tvalid = 1'b1;
      cmd_s_we     = we;
      cmd_s_addr   = a;
      cmd_s_wmask  = m;
      cmd_s_wdata  = d;
      rdy = 1'b0;
      for (int n = 0; n < 300; n++) begin
         rdy = cmd_s_tready;
         @(posedge clk);
         if (rdy) break;
         @(negedge clk);
      end
      @(negedge clk);
      cmd_s_tvalid = 1'b0;
      if (!rdy) begin
         n_vec++;
         n_err++;
         $display("FAIL accept_timeout addr=%h required=accepted", a);
      end else if (we) begin
         for (int i = 0; i < NB; i++)
            if (!m[i]) mdl[int'(a) * NB + i] = 8'(d >> (8 * (NB - 1 - i)));
         mdl_wr++;
      end else begin
         exp_q.push_back('{data: model_read(int'(a)), acc_cyc: cyc});
         n_rd_acc++;
      end
   endtask

   // Read with an idle pipeline and ready high: checks exact latency and the data value.
   task automatic read_direct(input logic [ADDR_W-1:0] a, input logic [63:0] req, input string name);
      int k;
      k = 0;
      send(1'b0, a, '0, '0);
      while (!rd_m_tvalid && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk({name, "_latency"}, 64'(k), 64'(LATENCY));
      chk(name, rd_m_tdata, req);
   endtask

   task automatic wait_drain(input string name);
      int k;
      k = 0;
      while ((exp_q.size() != 0 || rd_m_tvalid) && k < 2000) begin
         @(negedge clk);
         k++;
      end
      repeat (2) @(negedge clk);
      chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog time=%0t required=finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_tready", 64'(cmd_s_tready), 64'd0);
      chk("rst_tvalid", 64'(rd_m_tvalid), 64'd0);
      chk("rst_tdata", 64'(rd_m_tdata), 64'd0);
      chk("rst_wr_cnt", 64'(wr_cnt), 64'd0);
      chk("rst_rd_cnt", 64'(rd_cnt), 64'd0);
      rst = 1'b0;
      ready_mode = 1;
      repeat (2) @(negedge clk);
      chk("ready_after_rst", 64'(cmd_s_tready), 64'd1);

      send(1'b1, 25'h10, '0, 64'h0000_0000_DEAD_BEEF);
      read_direct(25'h10, 64'h0000_0000_DEAD_BEEF, "deadbeef");
      repeat (3) @(negedge clk);
      chk("wr_cnt_1", 64'(wr_cnt), 64'd1);
      chk("rd_cnt_1", 64'(rd_cnt), 64'd1);

      send(1'b1, 25'h20, '0, 64'hAAAA_AAAA_AAAA_AAAA);
      send(1'b1, 25'h20, 8'b0101_0101, 64'h1122_3344_5566_7788);
      read_direct(25'h20, 64'hAA22_AA44_AA66_AA88, "masked");

      send(1'b1, 25'h30, '0, 64'h5);
      read_direct(25'h30, 64'h5, "raw");
      wait_drain("directed");

      ready_mode = 0;
      repeat (3) @(negedge clk);
      begin
         int base;
         base = n_rd_acc;
         fork
            for (int i = 0; i < 6; i++) send(1'b0, ADDR_W'(8 + i), '0, '0);
            begin
               repeat (LATENCY + 10) @(negedge clk);
               chk("bp_accepted", 64'(n_rd_acc - base), 64'd4);
               chk("bp_tready_low", 64'(cmd_s_tready), 64'd0);
               chk("bp_tvalid", 64'(rd_m_tvalid), 64'd1);
               ready_mode = 1;
            end
         join
      end
      wait_drain("backpressure");
      chk("bp_rd_cnt", 64'(rd_cnt), 64'(n_pop));

      ready_mode = 0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++) send(1'b0, ADDR_W'(i), '0, '0);
      repeat (LATENCY + 3) @(negedge clk);
      chk("pre_rst_tvalid", 64'(rd_m_tvalid), 64'd1);
      @(posedge clk);
      #1 rst = 1'b1;
      exp_q.delete();
      #1;
      chk("async_rst_tvalid", 64'(rd_m_tvalid), 64'd0);
      chk("async_rst_tdata", 64'(rd_m_tdata), 64'd0);
      chk("async_rst_tready", 64'(cmd_s_tready), 64'd0);
      chk("async_rst_wr_cnt", 64'(wr_cnt), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      mdl_wr = 0;
      n_pop = 0;
      n_rd_acc = 0;
      ready_mode = 1;
      repeat (20) @(negedge clk);
      chk("no_stale_tvalid", 64'(rd_m_tvalid), 64'd0);
      read_direct(25'h30, 64'h5, "retained");
      wait_drain("post_reset");

      ready_mode = 2;
      for (int n = 0; n < 1000; n++) begin
         logic              we;
         logic [ADDR_W-1:0] a;
         logic [NB-1:0]     m;
         logic [DATA_W-1:0] d;
         we = 1'($urandom_range(0, 1));
         a  = ADDR_W'($urandom_range(0, 63));
         m  = NB'($urandom);
         d  = {$urandom, $urandom};
         send(we, a, m, d);
         if ($urandom_range(0, 3) == 0) @(negedge clk);
      end
      ready_mode = 1;
      wait_drain("random");
      chk("rand_rd_cnt", 64'(rd_cnt), 64'(n_rd_acc));
      chk("rand_rd_pops", 64'(n_pop), 64'(n_rd_acc));
      chk("rand_wr_cnt", 64'(wr_cnt), 64'(mdl_wr));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
